// File: rtl/mips_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_prog_loader: framed byte stream -> 32-bit words into MIPS32 memory     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mips_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              core_start,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [31:0]       C_MAX_WORDS = 32'(MEM_DEPTH - BASE_ADDR);
  localparam logic [ADDR_W-1:0] C_BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   C_ONE       = (ADDR_W + 1)'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_len;
  logic [23:0]     r_asm;
  logic [1:0]      r_bidx;
  logic [7:0]      r_csum;

  logic            w_accept;
  logic [15:0]     w_len;
  logic            w_len_bad;
  logic [ADDR_W:0] w_words_inc;
  logic            w_last_word;
  logic            w_word_done;
  logic            w_csum_ok;

  assign in_ready  = (r_state != S_DONE) && (r_state != S_ERR);
  assign load_done = (r_state == S_DONE);
  assign load_err  = (r_state == S_ERR);
  assign core_hold = (r_state != S_DONE);

  assign w_accept    = in_valid && in_ready;
  // Length check at full 32-bit width so large N never aliases after truncation
  assign w_len       = {r_len[15:8], in_data};
  assign w_len_bad   = {16'd0, w_len} > C_MAX_WORDS;
  assign w_words_inc = words_loaded + C_ONE;
  assign w_last_word = 32'(w_words_inc) == {16'd0, r_len};
  assign w_word_done = (r_bidx == 2'd3);
  assign w_csum_ok   = (in_data == r_csum);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept && in_data == 8'hA5) w_state_nxt = S_LEN_HI;
      S_LEN_HI: if (w_accept) w_state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_len_bad)          w_state_nxt = S_ERR;
          else if (w_len == 16'd0) w_state_nxt = S_CSUM;
          else                    w_state_nxt = S_DATA;
        end
      end
      S_DATA:   if (w_accept && w_word_done && w_last_word) w_state_nxt = S_CSUM;
      S_CSUM:   if (w_accept) w_state_nxt = w_csum_ok ? S_DONE : S_ERR;
      S_DONE,
      S_ERR:    if (restart) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      mem_we       <= 1'b0;
      mem_addr     <= C_BASE;
      mem_wdata    <= 32'd0;
      core_start   <= 1'b0;
      words_loaded <= '0;
      r_len        <= 16'd0;
      r_asm        <= 24'd0;
      r_bidx       <= 2'd0;
      r_csum       <= 8'd0;
    end else begin
      mem_we     <= 1'b0;
      core_start <= 1'b0;
      case (r_state)
        S_LEN_HI: if (w_accept) r_len[15:8] <= in_data;
        S_LEN_LO: if (w_accept) r_len[7:0]  <= in_data;
        S_DATA: begin
          if (w_accept) begin
            r_csum <= r_csum ^ in_data;
            if (w_word_done) begin
              mem_we       <= 1'b1;
              mem_addr     <= C_BASE + words_loaded[ADDR_W-1:0];
              mem_wdata    <= {r_asm, in_data};
              words_loaded <= w_words_inc;
              r_bidx       <= 2'd0;
            end else begin
              r_asm  <= {r_asm[15:0], in_data};
              r_bidx <= r_bidx + 2'd1;
            end
          end
        end
        S_CSUM: if (w_accept && w_csum_ok) core_start <= 1'b1;
        S_DONE,
        S_ERR: begin
          if (restart) begin
            words_loaded <= '0;
            r_csum       <= 8'd0;
            r_bidx       <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mips_prog_loader: table vectors, directed frames and random frames       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mips_prog_loader;
  localparam int ADDR_W    = 10;
  localparam int MEM_DEPTH = 1024;
  localparam int BASE_ADDR = 0;

  typedef logic [7:0] bq_t[$];

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              restart = 1'b0;
  logic              in_ready, mem_we, core_hold, core_start, load_done, load_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   words_loaded;

  always #5 clk1 = ~clk1;

  mips_prog_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_hold(core_hold), .core_start(core_start),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Write log observed on the memory port
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  always @(negedge clk1) if (rst_n && mem_we) begin
    wa_q.push_back(32'(mem_addr));
    wd_q.push_back(mem_wdata);
  end

  // Reference: parses the accepted byte stream by position within the frame
  logic [7:0]  m_buf[$];
  int          m_stat;   // 0 loading, 1 done, 2 error
  int          m_words;
  logic        m_we, m_start;
  logic [31:0] m_addr, m_data;

  function automatic void model_reset();
    m_buf.delete();
    m_stat = 0; m_words = 0; m_we = 1'b0; m_start = 1'b0; m_addr = 0; m_data = 0;
  endfunction

  function automatic void model_feed(input logic [7:0] b);
    int n, len, p;
    logic [7:0] x;
    if (m_buf.size() == 0 && b != 8'hA5) return;
    m_buf.push_back(b);
    n = m_buf.size();
    if (n < 3) return;
    len = int'({m_buf[1], m_buf[2]});
    p = n - 3;
    if (p == 0) begin
      if (len > MEM_DEPTH - BASE_ADDR) m_stat = 2;
      return;
    end
    if (p <= 4 * len) begin
      if (p % 4 == 0) begin
        m_we    = 1'b1;
        m_addr  = 32'(BASE_ADDR + p / 4 - 1);
        m_data  = {m_buf[n-4], m_buf[n-3], m_buf[n-2], m_buf[n-1]};
        m_words = p / 4;
      end
    end else begin
      x = 8'd0;
      for (int i = 3; i < n - 1; i++) x ^= m_buf[i];
      if (b == x) begin m_stat = 1; m_start = 1'b1; end
      else m_stat = 2;
    end
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d, input logic rs);
    m_we = 1'b0; m_start = 1'b0;
    if (m_stat != 0) begin
      if (rs) begin m_stat = 0; m_words = 0; m_buf.delete(); end
    end else if (v) model_feed(d);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'(m_stat == 0));
    chk({tag, " mem_we"}, 32'(mem_we), 32'(m_we));
    if (m_we) begin
      chk({tag, " mem_addr"}, 32'(mem_addr), m_addr);
      chk({tag, " mem_wdata"}, mem_wdata, m_data);
    end
    chk({tag, " core_start"}, 32'(core_start), 32'(m_start));
    chk({tag, " load_done"}, 32'(load_done), 32'(m_stat == 1));
    chk({tag, " load_err"}, 32'(load_err), 32'(m_stat == 2));
    chk({tag, " core_hold"}, 32'(core_hold), 32'(m_stat != 1));
    chk({tag, " words_loaded"}, 32'(words_loaded), 32'(m_words));
  endtask

  // Called at posedge+1; applies inputs for one clock and checks after the edge
  task automatic step(input logic v, input logic [7:0] d, input logic rs, input string tag);
    in_valid = v; in_data = d; restart = rs;
    model_step(v, d, rs);
    @(posedge clk1); #1;
    check_all(tag);
  endtask

  task automatic send_frame(input bq_t fr, input int gap, input logic rs_ok);
    foreach (fr[i]) begin
      repeat ($urandom_range(0, gap))
        step(1'b0, 8'($urandom), rs_ok && ($urandom_range(0, 15) == 0), "gap");
      step(1'b1, fr[i], 1'b0, "byte");
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'(BASE_ADDR));
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " core_hold"}, 32'(core_hold), 32'd1);
    chk({tag, " core_start"}, 32'(core_start), 32'd0);
    chk({tag, " load_done"}, 32'(load_done), 32'd0);
    chk({tag, " load_err"}, 32'(load_err), 32'd0);
    chk({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; restart = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    @(posedge clk1); #1;
    rst_n = 1'b1;
    model_reset();
    wa_q.delete(); wd_q.delete();
  endtask

  typedef struct {
    logic v; logic [7:0] d; logic rs;
    logic rdy; logic we; logic [ADDR_W-1:0] addr; logic [31:0] data;
    logic done; logic err; logic st; logic [ADDR_W:0] wl;
  } vec_t;
  vec_t tbl[$];

  function automatic void add_v(input logic v, input logic [7:0] d, input logic rs,
                                input logic rdy, input logic we, input logic [31:0] data,
                                input logic done, input logic err, input logic st, input int wl);
    vec_t e;
    e.v = v; e.d = d; e.rs = rs; e.rdy = rdy; e.we = we; e.addr = '0; e.data = data;
    e.done = done; e.err = err; e.st = st; e.wl = (ADDR_W + 1)'(wl);
    tbl.push_back(e);
  endfunction

  bq_t prog = '{8'hA5, 8'h00, 8'h06,
                8'h28, 8'h01, 8'h00, 8'h05, 8'h28, 8'h02, 8'h00, 8'h03,
                8'h00, 8'h22, 8'h18, 8'h00, 8'h24, 8'h03, 8'h00, 8'h64,
                8'h20, 8'h04, 8'h00, 8'h64, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hC0};
  logic [31:0] prog_w[6] = '{32'h28010005, 32'h28020003, 32'h00221800,
                             32'h24030064, 32'h20040064, 32'hFC000000};

  task automatic check_prog_writes(input string tag);
    chk({tag, " write count"}, 32'(wa_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < wa_q.size()) begin
        chk($sformatf("%s addr[%0d]", tag, i), wa_q[i], 32'(BASE_ADDR + i));
        chk($sformatf("%s data[%0d]", tag, i), wd_q[i], prog_w[i]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t fr;
    bq_t bad;
    logic [7:0] b, x;
    int len;

    // Reset state while rst_n is held low
    repeat (2) @(posedge clk1);
    #1 check_reset("reset");
    rst_n = 1'b1;
    model_reset();

    // Table: oversize length, empty frame, resync + single word, N == MEM_DEPTH
    //      v    d      rs    rdy   we    data           done  err   st    wl
    add_v(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 0);
    add_v(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 0);
    add_v(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 0);
    add_v(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 0);
    add_v(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'hDE, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'hAD, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'hBE, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'hEF, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1);
    add_v(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1);
    add_v(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
    add_v(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);

    @(posedge clk1); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; restart = tbl[i].rs;
      @(posedge clk1); #1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
        chk($sformatf("vec%0d mem_wdata", i), mem_wdata, tbl[i].data);
      end
      chk($sformatf("vec%0d load_done", i), 32'(load_done), 32'(tbl[i].done));
      chk($sformatf("vec%0d load_err", i), 32'(load_err), 32'(tbl[i].err));
      chk($sformatf("vec%0d core_start", i), 32'(core_start), 32'(tbl[i].st));
      chk($sformatf("vec%0d core_hold", i), 32'(core_hold), 32'(!tbl[i].done));
      chk($sformatf("vec%0d words_loaded", i), 32'(words_loaded), 32'(tbl[i].wl));
    end
    do_reset();

    // 6-word program, good checksum; in_valid held high in DONE
    send_frame(prog, 0, 1'b0);
    repeat (3) step(1'b1, 8'hA5, 1'b0, "done_hold");
    check_prog_writes("prog");
    step(1'b0, 8'h00, 1'b1, "restart_done");
    wa_q.delete(); wd_q.delete();

    // Same frame, corrupted checksum
    bad = prog;
    bad[bad.size()-1] = 8'hC1;
    send_frame(bad, 0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, "err_hold");
    check_prog_writes("badcsum");
    step(1'b0, 8'h00, 1'b1, "restart_err");
    wa_q.delete(); wd_q.delete();

    // Reset after the 2nd payload byte: no partial write
    for (int i = 0; i < 5; i++) step(1'b1, prog[i], 1'b0, "pre_reset");
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("midframe_reset");
    repeat (2) begin
      @(posedge clk1); #1;
      chk("in_reset mem_we", 32'(mem_we), 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    chk("midframe no write", 32'(wa_q.size()), 32'd0);
    send_frame(prog, 0, 1'b0);
    check_prog_writes("after_reset");
    step(1'b0, 8'h00, 1'b1, "restart");
    wa_q.delete(); wd_q.delete();

    // Random in_valid gaps over the program frame
    send_frame(prog, 3, 1'b0);
    repeat (2) step(1'b1, 8'($urandom), 1'b0, "done_valid");
    check_prog_writes("gappy");
    step(1'b0, 8'h00, 1'b1, "restart");

    // Random frames: junk prefix, random length/payload, bad checksums, oversize N
    for (int f = 0; f < 25; f++) begin
      fr.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        fr.push_back(b);
      end
      fr.push_back(8'hA5);
      if ($urandom_range(0, 7) == 0) begin
        fr.push_back(8'($urandom_range(5, 255)));
        repeat (3) fr.push_back(8'($urandom));
      end else begin
        len = $urandom_range(0, 6);
        fr.push_back(8'h00);
        fr.push_back(8'(len));
        x = 8'd0;
        repeat (4 * len) begin
          b = 8'($urandom);
          x ^= b;
          fr.push_back(b);
        end
        fr.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'h01) : x);
      end
      send_frame(fr, 2, 1'b1);
      repeat (2) step(1'b1, 8'($urandom), 1'b0, "rnd_tail");
      step(1'b0, 8'h00, 1'b1, "rnd_restart");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
